alu_sequencer: RTL and testbench

- Execute/writeback stage that wraps the combinational ALU.
- Accepts one ALU instruction per handshake, reads operands from an internal register file, and drives the ALU's input_A, input_B and mode_select for exactly one cycle.
- Captures output_C and flags, writes the result back, and holds the architectural flags register.
- Sits between instruction decode (upstream) and the ALU (downstream); the ALU is instantiated outside this block.

---
 rtl/alu_sequencer.sv | 92 +++++++++
 tb/tb_alu_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Execute/writeback stage around an external combinational ALU: reads operands
// from a small register file, drives the ALU for one cycle, writes back and keeps flags.
module alu_sequencer #(
    parameter int WORD_SIZE  = 8,
    parameter int NUM_REGS   = 4,
    parameter int REG_ADDR_W = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [3:0]            instr_op,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    input  logic [REG_ADDR_W-1:0] instr_rs,
    input  logic                  instr_imm_en,
    input  logic [WORD_SIZE-1:0]  instr_imm,
    output logic [WORD_SIZE-1:0]  alu_a,
    output logic [WORD_SIZE-1:0]  alu_b,
    output logic [3:0]            alu_mode,
    input  logic [WORD_SIZE-1:0]  alu_c,
    input  logic [7:0]            alu_flags,
    output logic [7:0]            flags_q,
    output logic                  done,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [WORD_SIZE-1:0]  dbg_data
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t                  state;
    logic [WORD_SIZE-1:0]    regs [NUM_REGS];
    logic [3:0]              op_q;
    logic [REG_ADDR_W-1:0]   rd_q;
    logic [WORD_SIZE-1:0]    res_q;
    logic [3:0]              flg_q;

    // Only Z/S/C/V are architectural; the ALU's low flag bits are dropped here.
    logic unused_flags;
    assign unused_flags = ^alu_flags[3:0];

    assign instr_ready = (state == IDLE);
    assign dbg_data    = regs[dbg_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            flags_q  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_mode <= '0;
            done     <= 1'b0;
            op_q     <= '0;
            rd_q     <= '0;
            res_q    <= '0;
            flg_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        op_q     <= instr_op;
                        rd_q     <= instr_rd;
                        alu_a    <= regs[instr_rd];
                        alu_b    <= instr_imm_en ? instr_imm : regs[instr_rs];
                        alu_mode <= instr_op;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    res_q    <= alu_c;
                    flg_q    <= alu_flags[7:4];
                    alu_mode <= '0;
                    done     <= 1'b1;
                    state    <= WB;
                end
                WB: begin
                    // Compare/test (2,3), nop (0) and flag clear (15) leave the register file alone.
                    if (!(op_q inside {4'd0, 4'd2, 4'd3, 4'd15}))
                        regs[rd_q] <= res_q;
                    if (op_q inside {[4'd2:4'd14]})
                        flags_q <= {flg_q, 4'b0000};
                    else if (op_q == 4'd15)
                        flags_q <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU stands in for the downstream unit and
// an instruction-level model predicts register file and flags.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd, instr_rs;
    logic       instr_imm_en;
    logic [7:0] instr_imm;
    logic [7:0] alu_a, alu_b, alu_c, alu_flags, flags_q, dbg_data;
    logic [3:0] alu_mode;
    logic       done;
    logic [1:0] dbg_addr;

    int checks = 0;
    int failures = 0;

    logic [7:0] mregs [4];
    logic [7:0] mflags;

    always #5 clk = ~clk;

    alu_sequencer #(.WORD_SIZE(8), .NUM_REGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
        .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_c(alu_c), .alu_flags(alu_flags),
        .flags_q(flags_q), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: {result, Z, S, C, V, low nibble of junk}
    function automatic logic [15:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [3:0] op);
        logic [8:0] w;
        logic [7:0] c;
        logic cy, v;
        cy = 1'b0; v = 1'b0; c = a;
        case (op)
            4'd0:  c = a;
            4'd1:  c = b;
            4'd2, 4'd7: begin
                w = {1'b0, a} - {1'b0, b}; c = w[7:0]; cy = w[8];
                v = (a[7] != b[7]) && (c[7] != a[7]);
            end
            4'd3, 4'd4: c = a & b;
            4'd5:  c = a | b;
            4'd6: begin
                w = {1'b0, a} + {1'b0, b}; c = w[7:0]; cy = w[8];
                v = (a[7] == b[7]) && (c[7] != a[7]);
            end
            4'd8:  c = a ^ b;
            4'd9:  c = ~a;
            4'd10: begin c = a << 1; cy = a[7]; end
            4'd11: begin c = a >> 1; cy = a[0]; end
            4'd12: c = a + 8'd1;
            4'd13: c = a - 8'd1;
            4'd14: begin w = {1'b0, a} + {1'b0, b} + 9'd1; c = w[7:0]; cy = w[8]; end
            default: c = 8'h00;
        endcase
        return {c, (c == 8'h00), c[7], cy, v, a[3:0] ^ b[3:0] ^ 4'h5};
    endfunction

    always_comb {alu_c, alu_flags} = alu_fn(alu_a, alu_b, alu_mode);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Architectural effect of one instruction, straight from the op-class rules.
    task automatic model_exec(logic [3:0] op, int rd, logic [7:0] a, logic [7:0] b);
        logic [15:0] r;
        r = alu_fn(a, b, op);
        if (!(op inside {4'd0, 4'd2, 4'd3, 4'd15})) mregs[rd] = r[15:8];
        if (op >= 4'd2 && op <= 4'd14) mflags = {r[7:4], 4'b0000};
        else if (op == 4'd15) mflags = 8'h00;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        mflags = 8'h00;
    endtask

    // Called and returns at a falling edge with the block idle.
    task automatic issue(logic [3:0] op, int rd, int rs, logic ie, logic [7:0] imm, logic noisy);
        logic [7:0] ea, eb;
        int n;
        ea = mregs[rd];
        eb = ie ? imm : mregs[rs];
        instr_op = op; instr_rd = 2'(rd); instr_rs = 2'(rs);
        instr_imm_en = ie; instr_imm = imm; instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 10) begin @(negedge clk); n++; end
        if (n >= 10) begin chk("issue_timeout", 0, 1); instr_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        instr_valid = noisy;
        if (noisy) begin
            instr_op = 4'($urandom); instr_rd = 2'($urandom); instr_rs = 2'($urandom);
            instr_imm_en = 1'($urandom); instr_imm = 8'($urandom);
        end
        chk("exec_mode", alu_mode, op);
        chk("exec_a", alu_a, ea);
        chk("exec_b", alu_b, eb);
        chk("exec_ready", instr_ready, 0);
        chk("exec_done", done, 0);
        @(negedge clk);
        chk("wb_done", done, 1);
        chk("wb_ready", instr_ready, 0);
        chk("wb_mode", alu_mode, 0);
        model_exec(op, rd, ea, eb);
        @(negedge clk);
        instr_valid = 1'b0;
        dbg_addr = 2'(rd);
        #1;
        chk("idle_done", done, 0);
        chk("idle_ready", instr_ready, 1);
        chk("reg_rd", dbg_data, mregs[rd]);
        chk("flags", flags_q, mflags);
    endtask

    typedef struct {
        logic [3:0] op;
        int         rd;
        int         rs;
        logic       ie;
        logic [7:0] imm;
        logic [7:0] er;
        logic [7:0] ef;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int acc, last, ph, ph_next;
        logic seen_done;

        tbl[0] = '{4'd1,  1, 0, 1'b1, 8'h7F, 8'h7F, 8'h00};
        tbl[1] = '{4'd6,  1, 0, 1'b1, 8'h01, 8'h80, 8'h50};
        tbl[2] = '{4'd1,  2, 0, 1'b1, 8'hFF, 8'hFF, 8'h50};
        tbl[3] = '{4'd6,  2, 0, 1'b1, 8'h01, 8'h00, 8'hA0};
        tbl[4] = '{4'd1,  3, 0, 1'b1, 8'h05, 8'h05, 8'hA0};
        tbl[5] = '{4'd2,  3, 0, 1'b1, 8'h05, 8'h05, 8'h80};
        tbl[6] = '{4'd15, 3, 0, 1'b1, 8'h33, 8'h05, 8'h00};
        tbl[7] = '{4'd6,  1, 1, 1'b0, 8'h00, 8'h00, 8'hB0};
        tbl[8] = '{4'd7,  3, 2, 1'b0, 8'hEE, 8'h05, 8'h00};
        tbl[9] = '{4'd4,  0, 1, 1'b0, 8'h00, 8'h00, 8'h80};

        rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs = '0;
        instr_imm_en = 1'b0; instr_imm = '0; dbg_addr = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_flags", flags_q, 8'h00);
        chk("rst_done", done, 0);
        chk("rst_mode", alu_mode, 0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            chk("rst_reg", dbg_data, 8'h00);
        end

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].ie, tbl[i].imm, 1'b0);
            dbg_addr = 2'(tbl[i].rd); #1;
            chk($sformatf("vec%0d_reg", i), dbg_data, tbl[i].er);
            chk($sformatf("vec%0d_flags", i), flags_q, tbl[i].ef);
        end

        // Back-to-back: valid held high with five increments of r0.
        instr_op = 4'd12; instr_rd = 2'd0; instr_rs = 2'd1; instr_imm_en = 1'b1; instr_imm = 8'h00;
        instr_valid = 1'b1;
        acc = 0; last = 0; ph = 0;
        for (int cyc = 0; cyc < 19; cyc++) begin
            if (acc == 5) instr_valid = 1'b0;
            chk("cont_ready", instr_ready, (ph == 0));
            chk("cont_mode", alu_mode, (ph == 1) ? 4'd12 : 4'd0);
            chk("cont_done", done, (ph == 2));
            if (instr_valid && instr_ready) begin
                acc++;
                if (acc > 1) chk("cont_spacing", cyc - last, 3);
                last = cyc;
                model_exec(4'd12, 0, mregs[0], 8'h00);
                ph_next = 1;
            end else begin
                ph_next = (ph == 1) ? 2 : 0;
            end
            @(posedge clk);
            ph = ph_next;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("cont_accepts", acc, 5);
        dbg_addr = 2'd0; #1;
        chk("cont_r0", dbg_data, mregs[0]);
        chk("cont_flags", flags_q, mflags);

        // Reset during EXEC drops the instruction.
        instr_op = 4'd1; instr_rd = 2'd0; instr_imm_en = 1'b1; instr_imm = 8'hAA; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("rstmid_exec_mode", alu_mode, 1);
        rst_n = 1'b0;
        seen_done = 1'b0;
        repeat (2) begin @(negedge clk); if (done) seen_done = 1'b1; end
        rst_n = 1'b1;
        model_reset();
        repeat (3) begin @(negedge clk); if (done) seen_done = 1'b1; end
        chk("rstmid_no_done", seen_done, 0);
        chk("rstmid_ready", instr_ready, 1);
        chk("rstmid_flags", flags_q, 8'h00);
        dbg_addr = 2'd0; #1;
        chk("rstmid_r0", dbg_data, 8'h00);

        // Randomised instruction stream against the model.
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom), 8'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            chk("final_reg", dbg_data, mregs[i]);
        end
        chk("final_flags", flags_q, mflags);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
